// File: rtl/fwd_pkg.sv
// fwd_pkg: shared constants, sizing helper and FSM encoding for the packet forwarder
package fwd_pkg;
  localparam int FWD_WIDTH_DEF = 32;
  localparam int BYTES = FWD_WIDTH_DEF / 8;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/fwd_out_fifo.sv
// fwd_out_fifo: first-word-fall-through FIFO with occupancy count
module fwd_out_fifo
  import fwd_pkg::*;
#(
  parameter int W = 37,
  parameter int DEPTH = 8,
  localparam int AW = clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
  assign empty = count == '0;
  // gate the head so the stream fields read zero whenever nothing is valid
  assign dout = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/axis_pkt_forwarder.sv
// axis_pkt_forwarder: reads a packet from memory via the width adapter and streams it out as AXIS
module axis_pkt_forwarder
  import fwd_pkg::*;
#(
  parameter int FWD_WIDTH = 8 * BYTES,
  parameter int FWD_ADDR_WIDTH = 10,
  parameter int RD_LAT = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int PLEN_WIDTH = FWD_ADDR_WIDTH + 3,
  localparam int BW = FWD_WIDTH / 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pkt_rdy,
  input  logic [PLEN_WIDTH-1:0]     pkt_len,
  output logic                      done,
  output logic [FWD_ADDR_WIDTH-1:0] fwd_addr,
  output logic                      fwd_rd_en,
  input  logic [FWD_WIDTH-1:0]      fwd_rd_data,
  output logic [FWD_WIDTH-1:0]      m_axis_tdata,
  output logic [BW-1:0]             m_axis_tkeep,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready
);
  localparam int FW = FWD_WIDTH + BW + 1;
  localparam int QW = clog2(FIFO_DEPTH) + 1;
  localparam int CW = clog2(FIFO_DEPTH + RD_LAT + 2) + 1;
  state_t state;
  logic [FWD_ADDR_WIDTH-1:0] word, last_word, last_word_d;
  logic [BW-1:0] last_keep, last_keep_d, rd_keep;
  logic rd_last, credit, empty;
  logic [PLEN_WIDTH-1:0] rem;
  logic [RD_LAT-1:0] p_vld, p_last;
  logic [RD_LAT-1:0][BW-1:0] p_keep;
  logic [QW-1:0] fifo_count;
  logic [CW-1:0] inflight;
  logic [FW-1:0] fifo_dout;
  always_comb begin
    rem = pkt_len % PLEN_WIDTH'(BW);
    last_word_d = FWD_ADDR_WIDTH'((pkt_len - PLEN_WIDTH'(1)) / PLEN_WIDTH'(BW));
    last_keep_d = (rem == '0) ? '1 : ~({BW{1'b1}} >> rem);
    // every read not yet popped holds a FIFO slot: queued, issued, or in the latency pipe
    inflight = CW'(fifo_count) + CW'(fwd_rd_en);
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(p_vld[i]);
  end
  assign credit = inflight < CW'(FIFO_DEPTH);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      done <= 1'b0;
      fwd_rd_en <= 1'b0;
      fwd_addr <= '0;
      word <= '0;
      last_word <= '0;
      last_keep <= '0;
      rd_keep <= '0;
      rd_last <= 1'b0;
    end else begin
      fwd_rd_en <= 1'b0;
      case (state)
        IDLE: if (pkt_rdy) begin
          last_word <= last_word_d;
          last_keep <= last_keep_d;
          if (pkt_len == '0) begin
            state <= DONE;
            done <= 1'b1;
          end else begin
            // word 0 issues on entry; the pipe and FIFO are empty between packets
            fwd_rd_en <= 1'b1;
            fwd_addr <= '0;
            word <= FWD_ADDR_WIDTH'(1);
            rd_last <= last_word_d == '0;
            rd_keep <= (last_word_d == '0) ? last_keep_d : '1;
            state <= (last_word_d == '0) ? DRAIN : READ;
          end
        end
        READ: if (credit) begin
          fwd_rd_en <= 1'b1;
          fwd_addr <= word;
          word <= word + FWD_ADDR_WIDTH'(1);
          rd_last <= word == last_word;
          rd_keep <= (word == last_word) ? last_keep : '1;
          if (word == last_word) state <= DRAIN;
        end
        DRAIN: if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
          state <= DONE;
          done <= 1'b1;
        end
        DONE: if (!pkt_rdy) begin
          state <= IDLE;
          done <= 1'b0;
        end
      endcase
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      p_vld <= '0;
      p_last <= '0;
      p_keep <= '0;
    end else begin
      p_vld[0] <= fwd_rd_en;
      p_last[0] <= rd_last;
      p_keep[0] <= rd_keep;
      for (int i = 1; i < RD_LAT; i++) begin
        p_vld[i] <= p_vld[i-1];
        p_last[i] <= p_last[i-1];
        p_keep[i] <= p_keep[i-1];
      end
    end
  fwd_out_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(p_vld[RD_LAT-1]),
    .din({fwd_rd_data, p_keep[RD_LAT-1], p_last[RD_LAT-1]}),
    .pop(m_axis_tvalid && m_axis_tready),
    .dout(fifo_dout),
    .empty(empty),
    .count(fifo_count)
  );
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast} = fifo_dout;
  assign m_axis_tvalid = !empty;
endmodule

// File: tb/tb_axis_pkt_forwarder.sv
// tb_axis_pkt_forwarder: directed checks of the forwarder against a latency-modelled packet memory
module tb_axis_pkt_forwarder;
  logic clk = 1'b0, rst = 1'b1, pkt_rdy = 1'b0, tready = 1'b0;
  logic [12:0] pkt_len = '0;
  logic done, rd_en, tlast, tvalid;
  logic [9:0] addr;
  logic [31:0] rd_data, tdata;
  logic [3:0] tkeep;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  axis_pkt_forwarder dut (
    .clk(clk), .rst(rst), .pkt_rdy(pkt_rdy), .pkt_len(pkt_len), .done(done),
    .fwd_addr(addr), .fwd_rd_en(rd_en), .fwd_rd_data(rd_data),
    .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tlast(tlast),
    .m_axis_tvalid(tvalid), .m_axis_tready(tready)
  );
  function automatic logic [31:0] wd(input logic [9:0] a);
    logic [11:0] b;
    b = {a, 2'b00};
    return {b[7:0], 8'(b + 12'd1), 8'(b + 12'd2), 8'(b + 12'd3)};
  endfunction
  logic [9:0] ap [4] = '{default: '0};
  always @(posedge clk) begin
    ap[0] <= addr;
    for (int i = 1; i < 4; i++) ap[i] <= ap[i-1];
  end
  assign rd_data = wd(ap[3]);
  logic [36:0] beats [$];
  logic [36:0] held;
  logic hold_pend = 1'b0;
  int rd_cnt = 0, tv_cnt = 0, hold_bad = 0;
  always @(negedge clk) begin
    #2;
    if (rst) hold_pend = 1'b0;
    else begin
      if (hold_pend && (!tvalid || {tdata, tkeep, tlast} !== held)) hold_bad++;
      hold_pend = tvalid && !tready;
      held = {tdata, tkeep, tlast};
      if (tvalid && tready) beats.push_back(held);
      if (rd_en) rd_cnt++;
      if (tvalid) tv_cnt++;
    end
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run_pkt(input int len, input int mode, input int budget,
                         output int fr, output int fv, output int dk);
    int r0;
    fr = -1; fv = -1; dk = -1; r0 = rd_cnt;
    pkt_len = 13'(len);
    pkt_rdy = 1'b1;
    tready = (mode == 0);
    @(posedge clk);
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk); #1;
      if (fr < 0 && rd_en) fr = k;
      if (fv < 0 && tvalid) fv = k;
      if (done) begin dk = k; break; end
      if (mode == 1) tready = 1'($urandom_range(0, 1));
      if (mode == 2 && k == 20) begin
        chk("bp_issue_cap", 64'(rd_cnt - r0), 64'd8);
        tready = 1'b1;
      end
    end
    if (dk < 0) chk("done_timeout", 64'(dk), 64'd0);
  endtask
  initial begin
    int fr, fv, dk, r0, t0, b0, errs;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({tvalid, tlast, tkeep, tdata, rd_en, addr, done}), 64'd0);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    b0 = beats.size(); r0 = rd_cnt;
    run_pkt(10, 0, 50, fr, fv, dk);
    chk("p10_first_rd", 64'(fr), 64'd1);
    chk("p10_first_valid", 64'(fv), 64'd6);
    chk("p10_done_cycle", 64'(dk), 64'd9);
    chk("p10_reads", 64'(rd_cnt - r0), 64'd3);
    chk("p10_beats", 64'(beats.size() - b0), 64'd3);
    chk("p10_beat0", 64'(beats[b0]), 64'({32'h00010203, 4'hF, 1'b0}));
    chk("p10_beat1", 64'(beats[b0+1]), 64'({32'h04050607, 4'hF, 1'b0}));
    chk("p10_beat2", 64'(beats[b0+2]), 64'({32'h08090A0B, 4'hC, 1'b1}));
    r0 = rd_cnt;
    repeat (10) @(negedge clk);
    #1;
    chk("hold_no_restart", 64'(rd_cnt - r0), 64'd0);
    chk("hold_done_high", 64'(done), 64'd1);
    pkt_rdy = 1'b0;
    @(negedge clk); #1;
    chk("done_clear", 64'(done), 64'd0);
    r0 = rd_cnt; t0 = tv_cnt;
    run_pkt(0, 0, 10, fr, fv, dk);
    chk("p0_done_cycle", 64'(dk), 64'd1);
    repeat (8) @(negedge clk);
    #1;
    chk("p0_no_reads", 64'(rd_cnt - r0), 64'd0);
    chk("p0_no_valid", 64'(tv_cnt - t0), 64'd0);
    pkt_rdy = 1'b0;
    @(negedge clk); #1;
    b0 = beats.size(); r0 = rd_cnt;
    run_pkt(64, 2, 200, fr, fv, dk);
    chk("bp_done", 64'(dk > 0), 64'd1);
    chk("bp_reads", 64'(rd_cnt - r0), 64'd16);
    chk("bp_beats", 64'(beats.size() - b0), 64'd16);
    errs = 0;
    for (int i = 0; i < 16 && b0 + i < beats.size(); i++)
      if (beats[b0+i] !== {wd(10'(i)), 4'hF, i == 15}) errs++;
    chk("bp_data", 64'(errs), 64'd0);
    pkt_rdy = 1'b0;
    @(negedge clk); #1;
    b0 = beats.size(); r0 = rd_cnt;
    run_pkt(4096, 1, 6000, fr, fv, dk);
    tready = 1'b1;
    chk("big_reads", 64'(rd_cnt - r0), 64'd1024);
    chk("big_beats", 64'(beats.size() - b0), 64'd1024);
    errs = 0;
    for (int i = 0; i < 1024 && b0 + i < beats.size(); i++)
      if (beats[b0+i] !== {wd(10'(i)), 4'hF, i == 1023}) errs++;
    chk("big_data", 64'(errs), 64'd0);
    chk("big_last_addr", 64'(addr), 64'd1023);
    chk("axis_hold_stable", 64'(hold_bad), 64'd0);
    pkt_rdy = 1'b0;
    @(negedge clk); #1;
    b0 = beats.size();
    pkt_len = 13'd64; pkt_rdy = 1'b1; tready = 1'b1;
    for (int k = 0; k < 100 && beats.size() - b0 < 5; k++) begin
      @(negedge clk); #1;
    end
    chk("rst_pre_beats", 64'(beats.size() - b0), 64'd5);
    rst = 1'b1;
    #1;
    chk("rst_async_outputs", 64'({tvalid, tlast, tkeep, tdata, rd_en, addr, done}), 64'd0);
    pkt_rdy = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    b0 = beats.size();
    run_pkt(8, 0, 50, fr, fv, dk);
    chk("p8_done_cycle", 64'(dk), 64'd8);
    chk("p8_beats", 64'(beats.size() - b0), 64'd2);
    chk("p8_beat0", 64'(beats[b0]), 64'({32'h00010203, 4'hF, 1'b0}));
    chk("p8_beat1", 64'(beats[b0+1]), 64'({32'h04050607, 4'hF, 1'b1}));
    pkt_rdy = 1'b0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axis_pkt_forwarder.md
Name: axis_pkt_forwarder

Overview:
- Downstream consumer of fwd_width_adapter. Reads a finished packet out of packet memory one FWD_WIDTH word at a time through the adapter's address/data interface.
- Emits the packet as an AXI-Stream master with TKEEP/TLAST, then hands the buffer back to the packet-memory controller with a 4-phase ready/done handshake.
- Hides the fixed adapter read latency and absorbs TREADY backpressure using a credit-limited output FIFO.

Parameters:
- FWD_WIDTH, 32, data width of adapter read port and of TDATA; multiple of 8.
- FWD_ADDR_WIDTH, 10, adapter word-address width.
- RD_LAT, 4, clock edges from fwd_addr/fwd_rd_en sampled to matching fwd_rd_data; must equal adapter plus memory latency.
- FIFO_DEPTH, 8, output FIFO entries; power of 2 and at least RD_LAT+2.
- PLEN_WIDTH, FWD_ADDR_WIDTH+3, byte-length width. Covers a full buffer of 2^FWD_ADDR_WIDTH*FWD_WIDTH/8 bytes.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- pkt_rdy  in  1  level; buffer holds a complete packet.
- pkt_len  in  PLEN_WIDTH  packet length in bytes; stable while pkt_rdy=1.
- done  out  1  level; packet fully forwarded; held until pkt_rdy falls.
- fwd_addr  out  FWD_ADDR_WIDTH  word address to adapter.
- fwd_rd_en  out  1  read issued this cycle.
- fwd_rd_data  in  FWD_WIDTH  adapter read data, RD_LAT cycles after the address.
- m_axis_tdata  out  FWD_WIDTH  stream data.
- m_axis_tkeep  out  FWD_WIDTH/8  byte enables.
- m_axis_tlast  out  1  final beat.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  sink ready.

Behaviour:
- Reset (async, any state, including mid-packet): state=IDLE, fwd_addr=0, fwd_rd_en=0, done=0, m_axis_tvalid=0, tlast=0, tkeep=0, tdata=0, FIFO empty, in-flight pipe cleared. Reads already in flight are discarded.
- Beats per packet: N = ceil(pkt_len/BYTES), where BYTES=FWD_WIDTH/8.
- Byte order: byte 0 of the packet is in TDATA[FWD_WIDTH-1 -: 8]. TKEEP bit i covers TDATA[8i+7:8i].
  - Last beat with r = pkt_len mod BYTES ≠ 0: the top r tkeep bits are set (32-bit example, r=3: 4'b1110).
  - All other beats: all tkeep bits set.
- FSM:
  - IDLE: on pkt_rdy=1, latch pkt_len, clear the word counter, and go to READ. If pkt_len=0, go straight to DONE.
  - READ: fwd_rd_en=1 iff credits are available. Credits available means fifo_count + inflight_count < FIFO_DEPTH.
    - fwd_addr starts at 0 and increments after each issued read.
    - After issuing word N-1, go to DRAIN.
  - DRAIN: wait for the beat with tlast to be accepted (tvalid & tready & tlast), then go to DONE.
  - DONE: done=1. When pkt_rdy=0, set done=0 and go to IDLE. A new packet is never accepted in the same cycle done is high.
- In-flight pipe: RD_LAT-stage shift register of {vld, last, keep}, aligned with fwd_rd_data.
  - On pipe output vld, write {fwd_rd_data, keep, last} into the FIFO.
  - Writes are guaranteed by credit accounting and never overflow.
- FIFO: first-word-fall-through. tvalid = !empty. Pop on tvalid & tready.
  - A simultaneous push and pop keeps the count unchanged.
  - A push into an empty FIFO is visible on tvalid the next cycle.
- Latency with tready=1: edge E samples pkt_rdy. The first read issues in cycle E+1. The first beat's tvalid rises at E+RD_LAT+2. Sustained throughput is 1 beat/cycle.
- tdata, tkeep and tlast are held stable while tvalid=1 and tready=0 (AXIS rule).
- fwd_addr holds its last value when fwd_rd_en=0.
- pkt_len is ignored outside IDLE.

Decomposition:
- Shared package (fwd_pkg): BYTES, the clog2 helper, and state encodings IDLE=0, READ=1, DRAIN=2, DONE=3.
- Sub-module: fwd_out_fifo, a parameterised FWFT FIFO with count output, width FWD_WIDTH+BYTES+1. Credit logic stays in the top level.

Test Plan:
- Test memory contents: every test models the adapter as a RD_LAT pipe over memory where byte k = k & 8'hFF.
- pkt_len=10, tready=1 -> 3 beats:
  - tdata 0x00010203 / 0x04050607 / 0x08090A0B.
  - tkeep F / F / C; tlast only on beat 3.
  - First tvalid at E+6 (RD_LAT=4).
  - done rises the cycle after the last beat is accepted; lowering pkt_rdy clears done the next cycle.
- pkt_len=64, tready held 0 for 20 cycles then 1 -> fwd_rd_en stops after exactly FIFO_DEPTH issues. Then 16 beats arrive in order with no duplicates or loss, tkeep=F on every beat.
- pkt_len=0 -> no fwd_rd_en and no tvalid; done=1 at E+1.
- Random tready (50%) with pkt_len=4096 -> 1024 beats, data matches the memory pattern, fwd_addr wraps 1023→stop, final tkeep=F.
- Async rst pulse mid-packet (beat 5 of 16) -> all outputs zero immediately. A subsequent pkt_len=8 packet yields exactly 0x00010203 / 0x04050607 with no stale beats.
- pkt_rdy held high after done -> no second packet starts until pkt_rdy falls and rises again.
